// File: rtl/fir_tap_sequencer_if.sv
// Bus bundle for fir_tap_sequencer: sample intake, coefficient port,
// multiplier/adder feed and result handshake.
interface fir_tap_sequencer_if #(
    parameter int DW   = 16,
    parameter int ACCW = 32,
    parameter int AW   = 2
);
    logic            s_valid;
    logic            s_ready;
    logic [DW-1:0]   s_data;
    logic            coef_we;
    logic [AW-1:0]   coef_addr;
    logic [DW-1:0]   coef_data;
    logic [DW-1:0]   mul_a;
    logic [DW-1:0]   mul_b;
    logic            op_valid;
    logic            acc_clr;
    logic [ACCW-1:0] acc_res;
    logic            y_valid;
    logic            y_ready;
    logic [ACCW-1:0] y_data;
    logic            busy;

    modport slave (
        input  s_valid, s_data, coef_we, coef_addr, coef_data, acc_res, y_ready,
        output s_ready, mul_a, mul_b, op_valid, acc_clr, y_valid, y_data, busy
    );

    modport master (
        output s_valid, s_data, coef_we, coef_addr, coef_data, acc_res, y_ready,
        input  s_ready, mul_a, mul_b, op_valid, acc_clr, y_valid, y_data, busy
    );
endinterface

// File: rtl/fir_tap_sequencer.sv
// FIR control/operand feed: circular sample line, coefficient file, tap
// issue to an external registered multiply/accumulate, result hold.
module fir_tap_sequencer #(
    parameter int NTAPS = 4,
    parameter int DW    = 16,
    parameter int ACCW  = 32,
    parameter int AW    = 2
) (
    input  logic                clk,
    input  logic                rst,
    fir_tap_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [DW-1:0]   r_smp  [NTAPS];
    logic [DW-1:0]   r_coef [NTAPS];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_newest;
    logic [AW-1:0]   r_tap;
    logic            r_run_done;
    logic            r_drain;
    logic            r_first;
    logic            r_acc_clr;
    logic            r_op_valid;
    logic [DW-1:0]   r_mul_a;
    logic [DW-1:0]   r_mul_b;
    logic [ACCW-1:0] r_y_data;
    logic            w_accept;
    logic [AW-1:0]   w_rd_idx;

    assign w_accept = (r_state == IDLE) && bus.s_valid;
    assign w_rd_idx = r_newest - r_tap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // RUN spans NTAPS issue edges plus one cycle showing the last tap.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.s_valid) w_state_nxt = RUN;
            RUN:     if (r_run_done)  w_state_nxt = DRAIN;
            DRAIN:   if (r_drain)     w_state_nxt = HOLD;
            HOLD:    if (bus.y_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NTAPS; i++) begin
                r_smp[i]  <= '0;
                r_coef[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_newest   <= '0;
            r_tap      <= '0;
            r_run_done <= 1'b0;
            r_drain    <= 1'b0;
            r_first    <= 1'b0;
            r_acc_clr  <= 1'b0;
            r_op_valid <= 1'b0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_y_data   <= '0;
        end else begin
            r_op_valid <= 1'b0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_first    <= 1'b0;
            r_acc_clr  <= r_first;
            r_drain    <= (r_state == DRAIN) && !r_drain;

            if (w_accept) begin
                r_smp[r_wr_ptr] <= bus.s_data;
                r_newest        <= r_wr_ptr;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end

            if (r_state == IDLE) begin
                r_run_done <= 1'b0;
                r_tap      <= '0;
                if (bus.coef_we) begin
                    r_coef[bus.coef_addr] <= bus.coef_data;
                end
            end

            if ((r_state == RUN) && !r_run_done) begin
                r_mul_a    <= r_smp[w_rd_idx];
                r_mul_b    <= r_coef[r_tap];
                r_op_valid <= 1'b1;
                r_first    <= (r_tap == '0);
                r_tap      <= r_tap + AW'(1);
                if (r_tap == AW'(NTAPS - 1)) begin
                    r_run_done <= 1'b1;
                end
            end

            // Accumulator holds the final sum on the second DRAIN cycle.
            if ((r_state == DRAIN) && r_drain) begin
                r_y_data <= bus.acc_res;
            end
        end
    end

    assign bus.s_ready  = (r_state == IDLE) && !rst;
    assign bus.busy     = (r_state != IDLE);
    assign bus.y_valid  = (r_state == HOLD);
    assign bus.y_data   = r_y_data;
    assign bus.op_valid = r_op_valid;
    assign bus.acc_clr  = r_acc_clr;
    assign bus.mul_a    = r_mul_a;
    assign bus.mul_b    = r_mul_b;
endmodule
